// File: rtl/vga_sync_rgb.sv
// VGA pixel-timing and output stage: free-running h/v counters, sync generation
// and a registered RGB path that is blanked outside the visible area.
module vga_sync_rgb #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    input  logic [7:0]       R_in,
    input  logic [7:0]       G_in,
    input  logic [7:0]       B_in,
    output logic [7:0]       R_out,
    output logic [7:0]       G_out,
    output logic [7:0]       B_out,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Everything presented on the pins for one pixel, kept together so it stays aligned.
    typedef struct packed {
        logic [7:0]       r;
        logic [7:0]       g;
        logic [7:0]       b;
        logic             hsync;
        logic             vsync;
        logic             video_on;
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
    } pix_out_t;

    localparam pix_out_t OUT_RESET = '{
        r:        8'h00,
        g:        8'h00,
        b:        8'h00,
        hsync:    ~SYNC_POL,
        vsync:    ~SYNC_POL,
        video_on: 1'b0,
        x:        '0,
        y:        '0
    };

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    pix_out_t         out_q, out_d;
    logic             frame_start_q, frame_start_d;
    logic             h_last, v_last, visible;

    assign h_last  = (h_cnt_q == H_LAST);
    assign v_last  = (v_cnt_q == V_LAST);
    assign visible = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + CNT_ONE;
            end else begin
                h_cnt_d = h_cnt_q + CNT_ONE;
            end
        end
    end

    // Outputs are derived from the pre-increment counts, giving one enable of latency.
    always_comb begin
        out_d          = OUT_RESET;
        out_d.x        = h_cnt_q;
        out_d.y        = v_cnt_q;
        out_d.video_on = visible;
        out_d.hsync    = (h_cnt_q >= HS_START && h_cnt_q < HS_END) ? SYNC_POL : ~SYNC_POL;
        out_d.vsync    = (v_cnt_q >= VS_START && v_cnt_q < VS_END) ? SYNC_POL : ~SYNC_POL;
        out_d.r        = visible ? R_in : 8'h00;
        out_d.g        = visible ? G_in : 8'h00;
        out_d.b        = visible ? B_in : 8'h00;
        frame_start_d  = pix_en && (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            out_q         <= OUT_RESET;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            if (pix_en) begin
                out_q <= out_d;
            end
            // Not gated by pix_en: the marker must drop after one clk whatever the enable duty.
            frame_start_q <= frame_start_d;
        end
    end

    assign R_out       = out_q.r;
    assign G_out       = out_q.g;
    assign B_out       = out_q.b;
    assign hsync       = out_q.hsync;
    assign vsync       = out_q.vsync;
    assign video_on    = out_q.video_on;
    assign pixel_x     = out_q.x;
    assign pixel_y     = out_q.y;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_rgb.sv
// Bench for vga_sync_rgb: full horizontal timing with a shortened frame height so
// whole frames fit in a short run; outputs compared each clk against a position model.
module tb_vga_sync_rgb;
    localparam int   H_ACTIVE = 640;
    localparam int   H_FP     = 16;
    localparam int   H_SYNC   = 96;
    localparam int   H_BP     = 48;
    localparam int   V_ACTIVE = 4;
    localparam int   V_FP     = 1;
    localparam int   V_SYNC   = 2;
    localparam int   V_BP     = 1;
    localparam logic SYNC_POL = 1'b0;
    localparam int   CNT_W    = 10;
    localparam int   H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic             clk = 1'b0;
    logic             rst_n, pix_en;
    logic [7:0]       R_in, G_in, B_in;
    logic [7:0]       R_out, G_out, B_out;
    logic             hsync, vsync, video_on, frame_start;
    logic [CNT_W-1:0] pixel_x, pixel_y;

    always #5 clk = ~clk;

    vga_sync_rgb #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .R_in(R_in), .G_in(G_in), .B_in(B_in),
        .R_out(R_out), .G_out(G_out), .B_out(B_out),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the number of enabled edges since reset fixes the pixel position.
    int unsigned pos = 0;
    int          cyc = 0;
    logic [7:0]       exp_r, exp_g, exp_b;
    logic             exp_hs, exp_vs, exp_vid, exp_fs;
    logic [CNT_W-1:0] exp_x, exp_y;

    // Pulse-width / period trackers; div is clks per enable in the current phase.
    int div    = 1;
    int hs_run = 0;
    int vs_run = 0;
    int last_fs = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b);
        int unsigned x, y;
        logic vis;
        @(negedge clk);
        rst_n  = rst;
        pix_en = en;
        R_in   = r;
        G_in   = g;
        B_in   = b;
        @(posedge clk);
        if (!rst) begin
            pos     = 0;
            exp_r   = 8'h00; exp_g = 8'h00; exp_b = 8'h00;
            exp_hs  = ~SYNC_POL; exp_vs = ~SYNC_POL;
            exp_vid = 1'b0; exp_fs = 1'b0;
            exp_x   = '0; exp_y = '0;
        end else begin
            exp_fs = 1'b0;
            if (en) begin
                x       = pos % H_TOTAL;
                y       = (pos / H_TOTAL) % V_TOTAL;
                vis     = (x < H_ACTIVE) && (y < V_ACTIVE);
                exp_x   = CNT_W'(x);
                exp_y   = CNT_W'(y);
                exp_vid = vis;
                exp_hs  = (x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL : ~SYNC_POL;
                exp_vs  = (y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL : ~SYNC_POL;
                exp_r   = vis ? r : 8'h00;
                exp_g   = vis ? g : 8'h00;
                exp_b   = vis ? b : 8'h00;
                exp_fs  = (x == 0) && (y == 0);
                pos++;
            end
        end
        #1;
        check("R_out",       32'(R_out),       32'(exp_r));
        check("G_out",       32'(G_out),       32'(exp_g));
        check("B_out",       32'(B_out),       32'(exp_b));
        check("hsync",       32'(hsync),       32'(exp_hs));
        check("vsync",       32'(vsync),       32'(exp_vs));
        check("video_on",    32'(video_on),    32'(exp_vid));
        check("pixel_x",     32'(pixel_x),     32'(exp_x));
        check("pixel_y",     32'(pixel_y),     32'(exp_y));
        check("frame_start", 32'(frame_start), 32'(exp_fs));

        if (!rst) begin
            hs_run  = 0;
            vs_run  = 0;
            last_fs = -1;
        end else begin
            if (hsync === SYNC_POL) begin
                if (hs_run == 0) check("hsync_start_x", 32'(pixel_x), 32'(H_ACTIVE + H_FP));
                hs_run++;
            end else if (hs_run > 0) begin
                check("hsync_width", 32'(hs_run), 32'(H_SYNC * div));
                hs_run = 0;
            end
            if (vsync === SYNC_POL) begin
                if (vs_run == 0) begin
                    check("vsync_start_y", 32'(pixel_y), 32'(V_ACTIVE + V_FP));
                    check("vsync_start_x", 32'(pixel_x), 32'd0);
                end
                vs_run++;
            end else if (vs_run > 0) begin
                check("vsync_width", 32'(vs_run), 32'(V_SYNC * H_TOTAL * div));
                vs_run = 0;
            end
            if (frame_start === 1'b1) begin
                if (last_fs >= 0) check("frame_period", 32'(cyc - last_fs), 32'(H_TOTAL * V_TOTAL * div));
                last_fs = cyc;
            end
        end
        cyc++;
    endtask

    initial begin
        rst_n  = 1'b0;
        pix_en = 1'b0;
        R_in   = 8'h00;
        G_in   = 8'h00;
        B_in   = 8'h00;

        // Reset with pix_en high: reset must win.
        repeat (3) step(1'b0, 1'b1, 8'hAA, 8'h55, 8'hCC);

        // First enabled edge after reset presents (0,0).
        step(1'b1, 1'b1, 8'h00, 8'hFF, 8'h00);

        // Rest of line 0 with a constant colour, then one full frame plus a bit of random colours.
        for (int i = 1; i < H_TOTAL; i++) step(1'b1, 1'b1, 8'h7F, 8'h7F, 8'h00);
        for (int i = 0; i < H_TOTAL * V_TOTAL + 10; i++)
            step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));

        // Half-rate enable; garbage colour on the idle clks must never reach the pins.
        div     = 2;
        last_fs = -1;
        for (int i = 0; i < 24200; i++) begin
            if (i % 2 == 0) step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
            else            step(1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
        end

        // Run on at full rate until (300,2) is on the pins, then pulse reset for one clk.
        div     = 1;
        last_fs = -1;
        for (int i = 0; i < H_TOTAL * V_TOTAL * 2; i++) begin
            if (exp_x == CNT_W'(300) && exp_y == CNT_W'(2)) break;
            step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        end
        step(1'b0, 1'b1, 8'h12, 8'h34, 8'h56);
        step(1'b1, 1'b1, 8'h9A, 8'hBC, 8'hDE);
        repeat (20) step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_sync_rgb.md
Name: vga_sync_rgb

Overview:
- Pixel-timing and output stage directly downstream of the colour-selection block.
- Generates horizontal and vertical counters plus HSYNC/VSYNC for a VGA frame.
- Registers the incoming 8-bit R/G/B from the colour selector and forces it to zero outside the visible area.
- Drives the DAC/connector pins, with pixel coordinates and a frame marker for other consumers.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
- CNT_W, 10, counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous, active-low reset
- pix_en  input  1  pixel-rate clock enable; tie to 1 when clk is the pixel clock
- R_in  input  8  red from colour selector
- G_in  input  8  green from colour selector
- B_in  input  8  blue from colour selector
- R_out  output  8  registered red to DAC
- G_out  output  8  registered green to DAC
- B_out  output  8  registered blue to DAC
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- video_on  output  1  high while the output pixel is visible
- pixel_x  output  CNT_W  column of the pixel currently on the outputs
- pixel_y  output  CNT_W  row of the pixel currently on the outputs
- frame_start  output  1  one-clk pulse when pixel (0,0) is presented

Behaviour:
- Reset and clocking
  - Single clock domain.
  - Reset is synchronous, active-low, and has priority over pix_en.
  - Reset values: h_cnt=0, v_cnt=0, R/G/B_out=0, hsync=vsync=~SYNC_POL (deasserted), video_on=0, pixel_x=pixel_y=0, frame_start=0.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counters advance only on clk edges with pix_en=1.
  - h_cnt increments and wraps H_TOTAL-1 -> 0.
  - On that wrap, v_cnt increments and wraps V_TOTAL-1 -> 0 (simultaneous wrap at the last pixel of the frame).
- Output registers load only on pix_en=1 edges and hold otherwise. Values are computed from pre-increment (h_cnt, v_cnt):
  - pixel_x=h_cnt, pixel_y=v_cnt
  - video_on = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE)
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL
  - vsync = SYNC_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, else ~SYNC_POL; it changes on the same edge as pixel_x reaching 0
  - R/G/B_out = R/G/B_in when video_on condition is true, else 8'h00
- Latency and alignment
  - One pix_en edge from counter value / RGB input sample to pins.
  - hsync, vsync, video_on, pixel_x/y and RGB are always mutually aligned.
- frame_start is 1 for exactly one clk after the edge loading (0,0), including the first pix_en edge after reset.
  - It is 0 on all other cycles, regardless of pix_en duty cycle.
- RGB inputs are sampled only on pix_en edges. Changes between enables are ignored; no hold requirement beyond that edge.
- Reset mid-frame: the next enabled edge after release restarts at (0,0), with no partial sync pulse continuation.
- Implementation is fully synchronous: no latches, no combinational path from inputs to outputs.

Test Plan:
- Reset, then pix_en=1, R/G/B_in=00/FF/00 -> first edge gives pixel_x=0, pixel_y=0, video_on=1, frame_start=1 for 1 clk, RGB_out=00/FF/00, hsync=vsync=1.
- Continuous pix_en, inputs 7F/7F/00 -> RGB_out=7F/7F/00 for x 0..639; 00/00/00 from x=640 through 799; hsync=0 for exactly 96 clks starting at pixel_x=656.
- Line wrap -> pixel_x 799 followed by 0 with pixel_y incremented. At line 479->480 video_on stays 0 for the whole line. vsync=0 for exactly 1600 clks beginning at pixel_y=490, pixel_x=0.
- Frame period -> frame_start pulses every 420000 clks; pixel_y wraps 524 -> 0.
- pix_en asserted every other clk -> outputs hold between enables; line length 1600 clks; frame_start still 1 clk wide; RGB_in changed on a non-enabled clk and restored before the next enable never appears at the outputs.
- rst_n low for 1 clk at pixel (300,200) -> all outputs at reset values on the next clk; next enabled edge presents (0,0) with frame_start=1.
